// File: rtl/shift_reg_univ.sv
// Universal shift register: shift left/right, parallel load, hold, optional rotate, with fill counter.
// Latency: sr_o/cnt_o/full_o/done_o registered (1 cycle); so_o combinational from sr_o and dir_i.
// Backpressure: none; every mode is accepted every cycle.
//
// Build option: define SHIFT_ROTATE_EN to enable mode 11 ROTATE; otherwise mode 11 holds.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset
//   clr_i   synchronous clear (same effect as reset)
//   mode_i  00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE/HOLD
//   dir_i   0 = left (serial in at LSB), 1 = right (serial in at MSB)
//   x_i     serial input bit
//   par_i   parallel load word
//   sr_o    register contents
//   so_o    serial out bit on the outgoing side for the current dir_i
//   cnt_o   bits shifted in since last clear/load (saturates at WIDTH)
//   full_o  cnt_o == WIDTH
//   done_o  one-cycle pulse when a shift fills the register
module shift_reg_univ #(
   parameter int                 WIDTH     = 4,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clr_i,
   input  logic [1:0]                   mode_i,
   input  logic                         dir_i,
   input  logic                         x_i,
   input  logic [WIDTH-1:0]             par_i,
   output logic [WIDTH-1:0]             sr_o,
   output logic                         so_o,
   output logic [$clog2(WIDTH+1)-1:0]   cnt_o,
   output logic                         full_o,
   output logic                         done_o
);

   localparam int CW = $clog2(WIDTH+1);

   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_SHIFT = 2'b01;
   localparam logic [1:0] MODE_LOAD  = 2'b10;
   localparam logic [1:0] MODE_ROT   = 2'b11;

   logic [WIDTH-1:0] sr_q,   sr_d;
   logic [CW-1:0]    cnt_q,  cnt_d;
   logic             done_q, done_d;

   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;

      if (clr_i) begin
         // A clear discards any partially assembled word.
         sr_d  = RESET_VAL;
         cnt_d = '0;
      end else begin
         case (mode_i)
            MODE_HOLD: begin
            end
            MODE_SHIFT: begin
               if (dir_i)
                  sr_d = {x_i, sr_q[WIDTH-1:1]};
               else
                  sr_d = {sr_q[WIDTH-2:0], x_i};
               // Saturate rather than wrap so full_o stays up while streaming.
               if (cnt_q != CNT_FULL)
                  cnt_d = cnt_q + CW'(1);
               // Pulse only on the shift that completes the word.
               done_d = (cnt_q == CNT_LAST);
            end
            MODE_LOAD: begin
               // A load counts as a full word but not as a fill event.
               sr_d  = par_i;
               cnt_d = CNT_FULL;
            end
`ifdef SHIFT_ROTATE_EN
            MODE_ROT: begin
               if (dir_i)
                  sr_d = {sr_q[0], sr_q[WIDTH-1:1]};
               else
                  sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
            end
`else
            MODE_ROT: begin
            end
`endif
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q   <= RESET_VAL;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign sr_o   = sr_q;
   assign cnt_o  = cnt_q;
   assign done_o = done_q;
   assign full_o = (cnt_q == CNT_FULL);
   assign so_o   = dir_i ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             clr_i;
   logic [1:0]       mode_i;
   logic             dir_i;
   logic             x_i;
   logic [WIDTH-1:0] par_i;
   logic [WIDTH-1:0] sr_o;
   logic             so_o;
   logic [2:0]       cnt_o;
   logic             full_o;
   logic             done_o;

   int checks = 0;
   int errors = 0;

   shift_reg_univ #(.WIDTH(WIDTH), .RESET_VAL(4'b0000)) dut (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (clr_i),
      .mode_i (mode_i),
      .dir_i  (dir_i),
      .x_i    (x_i),
      .par_i  (par_i),
      .sr_o   (sr_o),
      .so_o   (so_o),
      .cnt_o  (cnt_o),
      .full_o (full_o),
      .done_o (done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply inputs, take one rising edge, settle past it.
   task automatic step(input logic r, input logic c, input logic [1:0] m,
                       input logic d, input logic x, input logic [3:0] p);
      reset  = r;
      clr_i  = c;
      mode_i = m;
      dir_i  = d;
      x_i    = x;
      par_i  = p;
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [3:0] sr, input logic [2:0] cnt,
                              input logic full, input logic done);
      check({tag, ".sr"},   sr_o,   sr);
      check({tag, ".cnt"},  cnt_o,  cnt);
      check({tag, ".full"}, full_o, full);
      check({tag, ".done"}, done_o, done);
   endtask

   logic [3:0] exp_sr;
   logic [3:0] sh_bits;
   logic [3:0] so_exp;
   logic [3:0] rot_exp;

   initial begin
      reset = 1'b1; clr_i = 1'b0; mode_i = 2'b01; dir_i = 1'b0; x_i = 1'b1; par_i = 4'hF;

      // 1: reset dominates an active SHIFT
      step(1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 4'hF);
      step(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 4'hF);
      check_state("reset", 4'h0, 3'd0, 1'b0, 1'b0);
      check("reset.so", so_o, 1'b0);

      // 2: shift left 1,0,1,1 then a saturating 5th shift
      sh_bits = 4'b1101; // applied LSB first: 1,0,1,1
      exp_sr  = 4'h0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 2'b01, 1'b0, sh_bits[i], 4'h0);
         exp_sr = {exp_sr[2:0], sh_bits[i]};
         check_state($sformatf("sl%0d", i), exp_sr, 3'(i + 1), (i == 3), (i == 3));
      end
      check("sl.so", so_o, 1'b1);
      step(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'h0);
      check_state("sl_sat", 4'b0110, 3'd4, 1'b1, 1'b0);
      step(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'hF);
      check_state("hold", 4'b0110, 3'd4, 1'b1, 1'b0);

      // 3: LOAD 1001, serialise right with x_i=0
      step(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 4'b1001);
      check_state("load", 4'b1001, 3'd4, 1'b1, 1'b0);
      so_exp = 4'b1001;
      exp_sr = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         mode_i = 2'b01; dir_i = 1'b1; x_i = 1'b0;
         #1;
         check($sformatf("piso%0d.so", i), so_o, so_exp[i]);
         step(1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 4'h0);
         exp_sr = {1'b0, exp_sr[3:1]};
         check_state($sformatf("piso%0d", i), exp_sr, 3'd4, 1'b1, 1'b0);
      end

      // 4: clear mid-fill with mode=SHIFT, then a full refill
      step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
      check_state("clr0", 4'h0, 3'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 4'h0);
      check_state("part", 4'b0011, 3'd2, 1'b0, 1'b0);
      step(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 4'h0);
      check_state("clr_mid", 4'h0, 3'd0, 1'b0, 1'b0);
      exp_sr = 4'h0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 4'h0);
         exp_sr = {exp_sr[2:0], 1'b1};
         check_state($sformatf("refill%0d", i), exp_sr, 3'(i + 1), (i == 3), (i == 3));
      end
      // Clear on the would-be completing shift: no done pulse
      step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 4'h0);
      check_state("clr_last", 4'h0, 3'd0, 1'b0, 1'b0);

      // 5: mode 11, rotate when enabled, hold otherwise
      step(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 4'b1000);
`ifdef SHIFT_ROTATE_EN
      rot_exp = 4'b1000;
`endif
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 4'h0);
`ifdef SHIFT_ROTATE_EN
         rot_exp = {rot_exp[2:0], rot_exp[3]};
`else
         rot_exp = 4'b1000;
`endif
         check_state($sformatf("rotl%0d", i), rot_exp, 3'd4, 1'b1, 1'b0);
      end
      step(1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 4'h0);
`ifdef SHIFT_ROTATE_EN
      rot_exp = {rot_exp[0], rot_exp[3:1]};
`else
      rot_exp = 4'b1000;
`endif
      check_state("rotr", rot_exp, 3'd4, 1'b1, 1'b0);

      // 6: alternating direction, x_i=1, from cleared state
      step(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 4'h0);
      check_state("alt0", 4'b0001, 3'd1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 4'h0);
      check_state("alt1", 4'b1000, 3'd2, 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 4'h0);
      check_state("alt2", 4'b0001, 3'd3, 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 4'h0);
      check_state("alt3", 4'b1000, 3'd4, 1'b1, 1'b1);
      step(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 4'h0);
      check_state("alt_hold", 4'b1000, 3'd4, 1'b1, 1'b0);
      check("alt_hold.so_r", so_o, 1'b0);
      dir_i = 1'b0;
      #1;
      check("alt_hold.so_l", so_o, 1'b1);

      // Reset beats clr_i and LOAD
      step(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 4'hF);
      check_state("reset2", 4'h0, 3'd0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
